blockade_sound: RTL and testbench

Sound generator for the Blockade core. It sits directly downstream of the CPU's `OUTP`-qualified I/O write path: it consumes 8080 output-port writes and produces a single unsigned 8-bit mono sample stream for the audio DAC/mixer. It contains:
- a programmable square-wave tone channel (movement "beep");
- a 15-bit LFSR noise channel gated by a decaying envelope (crash sound).

---
 rtl/blockade_sound.sv | 135 +++++++++++++
 tb/tb_blockade_sound.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockade_sound.sv
// Blockade sound generator: decodes CPU output-port writes into a square-wave
// tone channel and an envelope-gated LFSR noise channel, mixed to 8-bit unsigned.
module blockade_sound #(
  parameter int TONE_PRESCALE  = 16,
  parameter int NOISE_PRESCALE = 64,
  parameter int ENV_PRESCALE   = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       io_wr,
  input  logic [1:0] io_addr,
  input  logic [7:0] io_data,
  output logic [7:0] audio_out,
  output logic       tone_active,
  output logic       noise_active
);

  localparam int TPW = $clog2(TONE_PRESCALE);
  localparam int NPW = $clog2(NOISE_PRESCALE);
  localparam int EPW = $clog2(ENV_PRESCALE);

  logic [TPW-1:0] tpre_q, tpre_d;
  logic [NPW-1:0] npre_q, npre_d;
  logic [EPW-1:0] epre_q, epre_d;
  logic [7:0]     period_q, period_d;
  logic           tone_en_q, tone_en_d;
  logic [3:0]     tone_vol_q, tone_vol_d;
  logic [7:0]     tone_cnt_q, tone_cnt_d;
  logic           square_q, square_d;
  logic [14:0]    lfsr_q, lfsr_d;
  logic [3:0]     env_q, env_d;
  logic [7:0]     audio_q, audio_d;
  logic           tone_act_q, tone_act_d;
  logic           noise_act_q, noise_act_d;
  logic           tone_tick, noise_tick, env_tick, trigger;

  // Sum of the two 4-bit channels never exceeds 30, so the x8 scale cannot wrap.
  function automatic logic [7:0] mix(input logic sq, input logic en,
                                     input logic [3:0] vol, input logic nbit,
                                     input logic [3:0] env);
    logic [4:0] t;
    logic [4:0] n;
    logic [4:0] sum;
    t   = (sq && en) ? {1'b0, vol} : 5'd0;
    n   = nbit ? {1'b0, env} : 5'd0;
    sum = t + n;
    return {sum, 3'b000};
  endfunction

  assign tone_tick  = (tpre_q == TPW'(TONE_PRESCALE - 1));
  assign noise_tick = (npre_q == NPW'(NOISE_PRESCALE - 1));
  assign env_tick   = (epre_q == EPW'(ENV_PRESCALE - 1));
  assign trigger    = io_wr && (io_addr == 2'd1) && io_data[1];

  always_comb begin
    tpre_d      = tone_tick  ? '0 : tpre_q + TPW'(1);
    npre_d      = noise_tick ? '0 : npre_q + NPW'(1);
    epre_d      = env_tick   ? '0 : epre_q + EPW'(1);
    period_d    = period_q;
    tone_en_d   = tone_en_q;
    tone_vol_d  = tone_vol_q;
    tone_cnt_d  = tone_cnt_q;
    square_d    = square_q;
    lfsr_d      = lfsr_q;
    env_d       = env_q;

    // Reload reads period_q, so a write in the same cycle only affects the next reload.
    if (tone_tick) begin
      if (period_q == 8'd0) begin
        tone_cnt_d = 8'd0;
        square_d   = 1'b0;
      end else if (tone_cnt_q == 8'd0) begin
        tone_cnt_d = period_q;
        square_d   = ~square_q;
      end else begin
        tone_cnt_d = tone_cnt_q - 8'd1;
      end
    end

    if (noise_tick) lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};

    if (trigger) env_d = 4'hF;
    else if (env_tick && (env_q != 4'd0)) env_d = env_q - 4'd1;

    if (io_wr) begin
      case (io_addr)
        2'd0:    period_d   = io_data;
        2'd1:    tone_en_d  = io_data[0];
        2'd2:    tone_vol_d = io_data[3:0];
        default: ;
      endcase
    end

    audio_d     = mix(square_q, tone_en_q, tone_vol_q, lfsr_q[0], env_q);
    tone_act_d  = tone_en_q && (period_q != 8'd0);
    noise_act_d = (env_q != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tpre_q      <= '0;
      npre_q      <= '0;
      epre_q      <= '0;
      period_q    <= 8'd0;
      tone_en_q   <= 1'b0;
      tone_vol_q  <= 4'd0;
      tone_cnt_q  <= 8'd0;
      square_q    <= 1'b0;
      lfsr_q      <= 15'h7FFF;
      env_q       <= 4'd0;
      audio_q     <= 8'd0;
      tone_act_q  <= 1'b0;
      noise_act_q <= 1'b0;
    end else begin
      tpre_q      <= tpre_d;
      npre_q      <= npre_d;
      epre_q      <= epre_d;
      period_q    <= period_d;
      tone_en_q   <= tone_en_d;
      tone_vol_q  <= tone_vol_d;
      tone_cnt_q  <= tone_cnt_d;
      square_q    <= square_d;
      lfsr_q      <= lfsr_d;
      env_q       <= env_d;
      audio_q     <= audio_d;
      tone_act_q  <= tone_act_d;
      noise_act_q <= noise_act_d;
    end
  end

  assign audio_out    = audio_q;
  assign tone_active  = tone_act_q;
  assign noise_active = noise_act_q;

endmodule

// File: tb/tb_blockade_sound.sv
// Bench for blockade_sound: register-map vector table, directed tone/noise
// corner sequences, and randomized writes checked against a cycle model.
module tb_blockade_sound;

  localparam int TP = 2;
  localparam int NP = 2;
  localparam int EP = 16;

  logic       clk;
  logic       reset_n;
  logic       io_wr;
  logic [1:0] io_addr;
  logic [7:0] io_data;
  logic [7:0] audio_out;
  logic       tone_active;
  logic       noise_active;

  blockade_sound #(
    .TONE_PRESCALE (TP),
    .NOISE_PRESCALE(NP),
    .ENV_PRESCALE  (EP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .io_wr       (io_wr),
    .io_addr     (io_addr),
    .io_data     (io_data),
    .audio_out   (audio_out),
    .tone_active (tone_active),
    .noise_active(noise_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name, input bit expired);
    checks++;
    if (expired) begin
      errors++;
      $display("FAIL %s wait expired at %0t", name, $time);
    end
  endtask

  // Reference model: prescaler ticks come from the cycle count since reset.
  int          m_cyc;
  logic [7:0]  m_period, m_tcnt, m_audio;
  logic        m_en, m_sq, m_ta, m_na;
  logic [3:0]  m_vol, m_env;
  logic [14:0] m_lfsr;
  int          m_t, m_n;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_cyc = 0; m_period = 0; m_tcnt = 0; m_audio = 0; m_en = 0; m_sq = 0;
      m_ta = 0; m_na = 0; m_vol = 0; m_env = 0; m_lfsr = 15'h7FFF;
    end else begin
      m_t = (m_sq && m_en) ? int'(m_vol) : 0;
      m_n = m_lfsr[0] ? int'(m_env) : 0;
      m_audio = 8'((m_t + m_n) * 8);
      m_ta = m_en && (m_period != 0);
      m_na = (m_env != 0);
      if (m_cyc % TP == TP - 1) begin
        if (m_period == 0) begin m_tcnt = 0; m_sq = 0; end
        else if (m_tcnt == 0) begin m_tcnt = m_period; m_sq = !m_sq; end
        else m_tcnt = m_tcnt - 1;
      end
      if (m_cyc % NP == NP - 1) m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
      if (io_wr && io_addr == 2'd1 && io_data[1]) m_env = 15;
      else if (m_cyc % EP == EP - 1 && m_env != 0) m_env = m_env - 1;
      if (io_wr) begin
        if (io_addr == 2'd0) m_period = io_data;
        else if (io_addr == 2'd1) m_en = io_data[0];
        else if (io_addr == 2'd2) m_vol = io_data[3:0];
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_audio", audio_out, m_audio);
      chk("model_tone_active", tone_active, m_ta);
      chk("model_noise_active", noise_active, m_na);
      chk("model_lfsr", dut.lfsr_q, m_lfsr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    io_wr = 1'b1; io_addr = a; io_data = d;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic wait_audio(input logic [7:0] v, input string name);
    int n = 0;
    while (audio_out !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    timeout(name, n >= 300);
  endtask

  task automatic run_len(input logic [7:0] v, output int len);
    len = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      io_wr = 1'b0;
      if (audio_out !== v) break;
      len++;
    end
  endtask

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic       ta;
    logic       na;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int len, n, bad;
    tbl[0] = '{2'd0, 8'h03, 1'b0, 1'b0};
    tbl[1] = '{2'd1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{2'd2, 8'h0F, 1'b1, 1'b0};
    tbl[3] = '{2'd3, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{2'd0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{2'd0, 8'h05, 1'b1, 1'b0};
    tbl[6] = '{2'd1, 8'hFC, 1'b0, 1'b0};
    tbl[7] = '{2'd1, 8'h03, 1'b1, 1'b1};
    tbl[8] = '{2'd1, 8'h01, 1'b1, 1'b1};
    tbl[9] = '{2'd1, 8'h00, 1'b0, 1'b1};

    reset_n = 1'b0; io_wr = 1'b0; io_addr = 2'd0; io_data = 8'd0;

    // Reset with random bus activity
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      io_wr = 1'($urandom); io_addr = 2'($urandom); io_data = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_audio", audio_out, 8'd0);
    chk("rst_tone_active", tone_active, 1'b0);
    chk("rst_noise_active", noise_active, 1'b0);
    chk("rst_lfsr", dut.lfsr_q, 15'h7FFF);
    chk_en = 1;
    reset_n = 1'b1; io_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("idle_audio", audio_out, 8'd0);
      if (i == 1) chk("lfsr_shift1", dut.lfsr_q, 15'h7FFE);
      if (i == 3) chk("lfsr_shift2", dut.lfsr_q, 15'h7FFC);
    end

    // Register map vectors
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].a, tbl[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d_tone_active", i), tone_active, tbl[i].ta);
      chk($sformatf("vec%0d_noise_active", i), noise_active, tbl[i].na);
    end
    repeat (300) @(negedge clk);

    // Tone: period 3 gives 8-clock half periods at full volume
    wr(2'd0, 8'd3); wr(2'd1, 8'h01); wr(2'd2, 8'h0F);
    wait_audio(8'd0, "tone_wait_low");
    wait_audio(8'd120, "tone_wait_high");
    run_len(8'd120, len); chk("tone_high_len", len, 8);
    run_len(8'd0, len);   chk("tone_low_len", len, 8);
    chk("tone_active_on", tone_active, 1'b1);
    // Now at the first high sample: period 3->1 applies only at the next reload
    io_wr = 1'b1; io_addr = 2'd0; io_data = 8'd1;
    run_len(8'd120, len); chk("reload_old_len", len, 8);
    run_len(8'd0, len);   chk("reload_new_len", len, 4);
    run_len(8'd120, len); chk("reload_new_len2", len, 4);
    wr(2'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("period0_audio", audio_out, 8'd0);
    chk("period0_tone_active", tone_active, 1'b0);

    // Noise: trigger and full envelope decay
    wr(2'd1, 8'h02);
    chk("noise_lag", noise_active, 1'b0);
    len = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!noise_active) break;
      len++;
    end
    checks++;
    if (len < 225 || len > 240) begin
      errors++;
      $display("FAIL noise_decay_len actual=%0d required=225..240", len);
    end

    // Retrigger exactly on an env tick while env is 5
    wr(2'd1, 8'h02);
    n = 0;
    while (!(m_env == 4'd5 && (m_cyc % EP) == EP - 1) && n < 600) begin
      @(negedge clk);
      n++;
    end
    timeout("collide_wait", n >= 600);
    io_wr = 1'b1; io_addr = 2'd1; io_data = 8'h02;
    @(negedge clk);
    io_wr = 1'b0;
    chk("collide_env", dut.env_q, 4'd15);
    n = 0;
    while (m_env != 4'd0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    timeout("env_zero_wait", n >= 600);
    @(negedge clk);
    chk("env_zero_noise_active", noise_active, 1'b0);
    wr(2'd1, 8'h02);
    chk("retrig_env", dut.env_q, 4'd15);
    @(negedge clk);
    chk("retrig_noise_active", noise_active, 1'b1);

    // Reset during active tone and noise, with a concurrent period write
    wr(2'd0, 8'd4); wr(2'd2, 8'd9); wr(2'd1, 8'h03);
    repeat (20) @(negedge clk);
    reset_n = 1'b0; io_wr = 1'b1; io_addr = 2'd0; io_data = 8'd9;
    @(negedge clk);
    chk("midrst_audio", audio_out, 8'd0);
    chk("midrst_tone_active", tone_active, 1'b0);
    chk("midrst_noise_active", noise_active, 1'b0);
    chk("midrst_lfsr", dut.lfsr_q, 15'h7FFF);
    reset_n = 1'b1; io_wr = 1'b0;
    wr(2'd2, 8'h0F); wr(2'd1, 8'h01);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (audio_out !== 8'd0 || tone_active !== 1'b0) bad++;
    end
    chk("midrst_period_dropped", bad, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      io_wr   = ($urandom_range(3) == 0);
      io_addr = 2'($urandom);
      io_data = 8'($urandom);
      reset_n = ($urandom_range(399) != 0);
    end
    @(negedge clk);
    io_wr = 1'b0; reset_n = 1'b1;
    repeat (5) @(negedge clk);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
